// File: rtl/testchip_clk_pkg.sv
// Shared types and helpers for the testchip multi-channel clock divider.
package testchip_clk_pkg;

    typedef enum logic [1:0] {
        OFF  = 2'b00,
        RUN  = 2'b01,
        STOP = 2'b10
    } chan_state_e;

    localparam int DIV_MIN = 2;

    function automatic logic [31:0] bin2gray(input logic [31:0] bin);
        return bin ^ (bin >> 1);
    endfunction

endpackage

// File: rtl/testchip_clkdiv_ch.sv
// One divided-clock channel: ratio latch, phase counter and OFF/RUN/STOP FSM.
module testchip_clkdiv_ch
    import testchip_clk_pkg::*;
#(
    parameter int DIV_W = 4
) (
    input  logic             noc_clk,
    input  logic             noc_reset_n,
    input  logic [DIV_W-1:0] div_sel,
    input  logic             en,
    output logic             clk_div,
    output logic             active,
    output logic             upd_ack
);

    chan_state_e      state_r;
    chan_state_e      state_nxt_s;
    logic [DIV_W-1:0] cnt_r;
    logic [DIV_W-1:0] cnt_nxt_s;
    logic [DIV_W-1:0] n_act_r;
    logic [DIV_W-1:0] n_act_nxt_s;
    logic [DIV_W-1:0] n_eff_s;
    logic [DIV_W-1:0] half_s;
    logic             sel_zero_s;
    logic             wrap_s;
    logic             clk_r;
    logic             clk_nxt_s;
    logic             active_r;
    logic             ack_r;
    logic             ack_nxt_s;

    // Next-state, counter, ratio adoption and next output level
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        n_act_nxt_s = n_act_r;
        ack_nxt_s   = 1'b0;
        sel_zero_s  = (div_sel == {DIV_W{1'b0}});
        n_eff_s     = (div_sel < DIV_W'(DIV_MIN)) ? DIV_W'(DIV_MIN) : div_sel;
        wrap_s      = (cnt_r == (n_act_r - DIV_W'(1)));

        case (state_r)
            OFF: begin
                cnt_nxt_s = {DIV_W{1'b0}};
                if (en && !sel_zero_s) begin
                    state_nxt_s = RUN;
                    n_act_nxt_s = n_eff_s;
                end else begin
                    state_nxt_s = OFF;
                end
            end
            RUN, STOP: begin
                if (wrap_s) begin
                    // Ratio changes and shutdown only take effect on a period boundary
                    cnt_nxt_s = {DIV_W{1'b0}};
                    if (!en || sel_zero_s) begin
                        state_nxt_s = OFF;
                    end else begin
                        state_nxt_s = RUN;
                        if (n_eff_s != n_act_r) begin
                            n_act_nxt_s = n_eff_s;
                            ack_nxt_s   = 1'b1;
                        end else begin
                            n_act_nxt_s = n_act_r;
                        end
                    end
                end else begin
                    cnt_nxt_s = cnt_r + DIV_W'(1);
                    if (!en) begin
                        state_nxt_s = STOP;
                    end else begin
                        state_nxt_s = state_r;
                    end
                end
            end
            default: begin
                state_nxt_s = OFF;
                cnt_nxt_s   = {DIV_W{1'b0}};
            end
        endcase

        half_s    = {1'b0, n_act_nxt_s[DIV_W-1:1]};
        clk_nxt_s = (state_nxt_s != OFF) && (cnt_nxt_s < half_s);
    end

    // Channel state and output registers
    always_ff @(posedge noc_clk or negedge noc_reset_n) begin
        if (!noc_reset_n) begin
            state_r  <= OFF;
            cnt_r    <= {DIV_W{1'b0}};
            n_act_r  <= {DIV_W{1'b0}};
            clk_r    <= 1'b0;
            active_r <= 1'b0;
            ack_r    <= 1'b0;
        end else begin
            state_r  <= state_nxt_s;
            cnt_r    <= cnt_nxt_s;
            n_act_r  <= n_act_nxt_s;
            clk_r    <= clk_nxt_s;
            active_r <= (state_nxt_s != OFF);
            ack_r    <= ack_nxt_s;
        end
    end

    assign clk_div = clk_r;
    assign active  = active_r;
    assign upd_ack = ack_r;

endmodule

// File: rtl/testchip_clkdiv_mc.sv
// Multi-channel glitch-free clock divider with gray phase counter and scan bypass.
module testchip_clkdiv_mc
    import testchip_clk_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int DIV_W  = 4,
    parameter int GRAY_W = 3
) (
    input  logic                    noc_clk,
    input  logic                    noc_reset_n,
    input  logic                    scanmode,
    input  logic [NUM_CH*DIV_W-1:0] ch_div_sel,
    input  logic [NUM_CH-1:0]       ch_en,
    output logic [NUM_CH-1:0]       ch_clk_out,
    output logic [NUM_CH-1:0]       ch_active,
    output logic [NUM_CH-1:0]       ch_upd_ack,
    input  logic                    gray_en,
    output logic [GRAY_W-1:0]       gray_cnt
);

    logic [NUM_CH-1:0] div_clk_s;
    logic [GRAY_W-1:0] bin_r;
    logic [GRAY_W-1:0] bin_nxt_s;
    logic [GRAY_W-1:0] gray_r;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        testchip_clkdiv_ch #(
            .DIV_W (DIV_W)
        ) u_ch (
            .noc_clk     (noc_clk),
            .noc_reset_n (noc_reset_n),
            .div_sel     (ch_div_sel[i*DIV_W +: DIV_W]),
            .en          (ch_en[i]),
            .clk_div     (div_clk_s[i]),
            .active      (ch_active[i]),
            .upd_ack     (ch_upd_ack[i])
        );
    end

    // Scan bypass routes the source clock straight to every channel
    assign ch_clk_out = scanmode ? {NUM_CH{noc_clk}} : div_clk_s;

    // Binary phase advance; disabling clears it synchronously
    always_comb begin
        if (gray_en) begin
            bin_nxt_s = bin_r + GRAY_W'(1);
        end else begin
            bin_nxt_s = {GRAY_W{1'b0}};
        end
    end

    // Binary counter and registered gray encoding of its next value
    always_ff @(posedge noc_clk or negedge noc_reset_n) begin
        if (!noc_reset_n) begin
            bin_r  <= {GRAY_W{1'b0}};
            gray_r <= {GRAY_W{1'b0}};
        end else begin
            bin_r  <= bin_nxt_s;
            gray_r <= GRAY_W'(bin2gray(32'(bin_nxt_s)));
        end
    end

    assign gray_cnt = gray_r;

endmodule

// File: tb/tb_testchip_clkdiv_mc.sv
// Self-checking bench for testchip_clkdiv_mc: vector table, corner sequences, random vs. model.
module tb_testchip_clkdiv_mc;

    localparam int NUM_CH = 4;
    localparam int DIV_W  = 4;
    localparam int GRAY_W = 3;

    logic                    noc_clk;
    logic                    noc_reset_n;
    logic                    scanmode;
    logic [NUM_CH*DIV_W-1:0] ch_div_sel;
    logic [NUM_CH-1:0]       ch_en;
    logic [NUM_CH-1:0]       ch_clk_out;
    logic [NUM_CH-1:0]       ch_active;
    logic [NUM_CH-1:0]       ch_upd_ack;
    logic                    gray_en;
    logic [GRAY_W-1:0]       gray_cnt;

    testchip_clkdiv_mc #(
        .NUM_CH (NUM_CH),
        .DIV_W  (DIV_W),
        .GRAY_W (GRAY_W)
    ) dut (
        .noc_clk     (noc_clk),
        .noc_reset_n (noc_reset_n),
        .scanmode    (scanmode),
        .ch_div_sel  (ch_div_sel),
        .ch_en       (ch_en),
        .ch_clk_out  (ch_clk_out),
        .ch_active   (ch_active),
        .ch_upd_ack  (ch_upd_ack),
        .gray_en     (gray_en),
        .gray_cnt    (gray_cnt)
    );

    initial noc_clk = 1'b0;
    always #5 noc_clk = ~noc_clk;

    int n_chk  = 0;
    int n_pass = 0;

    // Reference model: each running channel holds the remaining waveform of its current period
    bit       mq[NUM_CH][$];
    int       m_ratio[NUM_CH];
    bit [3:0] m_ack;
    int       gk;
    int       gtab[8] = '{0, 1, 3, 2, 6, 7, 5, 4};

    typedef struct {
        logic [3:0]  sel;
        int          ncyc;
        logic [15:0] pat;
        logic        act;
    } vec_t;
    vec_t tbl[6];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        else n_pass++;
    endtask

    task automatic model_reset();
        for (int i = 0; i < NUM_CH; i++) begin
            mq[i].delete();
            m_ratio[i] = 0;
        end
        m_ack = 4'd0;
        gk    = 0;
    endtask

    task automatic model_step();
        for (int i = 0; i < NUM_CH; i++) begin
            bit ended;
            int sel;
            int neff;
            ended = 1'b0;
            if (mq[i].size() > 0) begin
                void'(mq[i].pop_front());
                ended = (mq[i].size() == 0);
            end
            m_ack[i] = 1'b0;
            if (mq[i].size() == 0) begin
                sel = int'(ch_div_sel[i*DIV_W +: DIV_W]);
                if (ch_en[i] && sel != 0) begin
                    neff       = (sel < 2) ? 2 : sel;
                    m_ack[i]   = ended && (neff != m_ratio[i]);
                    m_ratio[i] = neff;
                    for (int k = 0; k < neff; k++) mq[i].push_back(k < neff / 2);
                end
            end
        end
        gk = gray_en ? (gk + 1) % 8 : 0;
    endtask

    function automatic logic [3:0] m_clk();
        logic [3:0] r;
        for (int i = 0; i < NUM_CH; i++) r[i] = (mq[i].size() > 0) ? mq[i][0] : 1'b0;
        return r;
    endfunction

    function automatic logic [3:0] m_act();
        logic [3:0] r;
        for (int i = 0; i < NUM_CH; i++) r[i] = (mq[i].size() > 0);
        return r;
    endfunction

    task automatic tick();
        @(posedge noc_clk);
        model_step();
        #1;
        check("clk", 32'(ch_clk_out), scanmode ? 32'hF : 32'(m_clk()));
        check("active", 32'(ch_active), 32'(m_act()));
        check("ack", 32'(ch_upd_ack), 32'(m_ack));
        check("gray", 32'(gray_cnt), gtab[gk]);
    endtask

    // Asynchronous reset away from the clock edge, checked immediately
    task automatic do_reset();
        #2;
        noc_reset_n = 1'b0;
        #1;
        check("rst_clk", 32'(ch_clk_out), 32'h0);
        check("rst_act", 32'(ch_active), 32'h0);
        check("rst_ack", 32'(ch_upd_ack), 32'h0);
        check("rst_gray", 32'(gray_cnt), 32'h0);
        model_reset();
        @(posedge noc_clk);
        #1;
        noc_reset_n = 1'b1;
    endtask

    initial begin
        logic [11:0] rec_clk;
        logic [11:0] rec_ack;
        logic [11:0] rec_act;
        int          gexp[9] = '{1, 3, 2, 6, 7, 5, 4, 0, 1};

        noc_reset_n = 1'b0;
        scanmode    = 1'b0;
        ch_div_sel  = 16'h0000;
        ch_en       = 4'h0;
        gray_en     = 1'b0;
        model_reset();

        tbl[0] = '{4'd4,  8,  16'h0033, 1'b1};
        tbl[1] = '{4'd5,  10, 16'h0063, 1'b1};
        tbl[2] = '{4'd1,  8,  16'h0055, 1'b1};
        tbl[3] = '{4'd0,  8,  16'h0000, 1'b0};
        tbl[4] = '{4'd3,  6,  16'h0009, 1'b1};
        tbl[5] = '{4'd15, 16, 16'h807F, 1'b1};

        do_reset();

        // Table: enable channel 0 from OFF and compare its waveform
        for (int t = 0; t < 6; t++) begin
            do_reset();
            ch_div_sel = {12'h000, tbl[t].sel};
            ch_en      = 4'h1;
            for (int c = 0; c < tbl[t].ncyc; c++) begin
                tick();
                check($sformatf("tbl%0d_clk%0d", t, c), 32'(ch_clk_out[0]), 32'(tbl[t].pat[c]));
                check($sformatf("tbl%0d_act%0d", t, c), 32'(ch_active[0]), 32'(tbl[t].act));
            end
            ch_en = 4'h0;
        end

        // Ratio change 6 -> 3 at cnt=2
        do_reset();
        ch_div_sel = 16'h0006;
        ch_en      = 4'h1;
        for (int c = 0; c < 12; c++) begin
            tick();
            rec_clk[c] = ch_clk_out[0];
            rec_ack[c] = ch_upd_ack[0];
            if (c == 2) ch_div_sel = 16'h0003;
        end
        check("upd_clk_seq", 32'(rec_clk), 32'h247);
        check("upd_ack_seq", 32'(rec_ack), 32'h040);

        // Disable at cnt=1 of a divide-by-8 period
        do_reset();
        ch_div_sel = 16'h0008;
        ch_en      = 4'h1;
        rec_clk    = 12'h000;
        rec_act    = 12'h000;
        for (int c = 0; c < 9; c++) begin
            tick();
            rec_clk[c] = ch_clk_out[0];
            rec_act[c] = ch_active[0];
            if (c == 1) ch_en = 4'h0;
        end
        check("stop_clk_seq", 32'(rec_clk), 32'h00F);
        check("stop_act_seq", 32'(rec_act), 32'h0FF);

        // Gray sequence and synchronous clear
        do_reset();
        gray_en = 1'b1;
        for (int c = 0; c < 9; c++) begin
            tick();
            check($sformatf("gray_seq%0d", c), 32'(gray_cnt), gexp[c]);
        end
        gray_en = 1'b0;
        tick();
        check("gray_clear", 32'(gray_cnt), 32'h0);

        // All channels high mid-period, then asynchronous reset and restart
        do_reset();
        ch_div_sel = {4'd7, 4'd6, 4'd5, 4'd4};
        ch_en      = 4'hF;
        gray_en    = 1'b1;
        tick();
        tick();
        check("pre_rst_clk", 32'(ch_clk_out), 32'hF);
        do_reset();
        tick();
        check("restart_clk", 32'(ch_clk_out), 32'hF);
        check("restart_ack", 32'(ch_upd_ack), 32'h0);

        // Scan bypass on both clock levels while channels keep running
        scanmode = 1'b1;
        for (int c = 0; c < 4; c++) begin
            tick();
            #5;
            check("scan_low", 32'(ch_clk_out), 32'h0);
        end
        scanmode = 1'b0;

        // Randomized traffic against the model
        for (int c = 0; c < 800; c++) begin
            for (int i = 0; i < NUM_CH; i++) begin
                if ($urandom_range(0, 15) == 0) ch_en[i] = ~ch_en[i];
                if ($urandom_range(0, 9) == 0) ch_div_sel[i*DIV_W +: DIV_W] = 4'($urandom_range(0, 9));
            end
            if ($urandom_range(0, 19) == 0) gray_en = ~gray_en;
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
